// File: rtl/mmc3_irq_counter.sv
// MMC3-style scanline IRQ counter. Filtered rising edges of PPU A12 clock an
// 8-bit reload/down counter, and the active-low irq is raised when it reaches zero.
module mmc3_irq_counter #(
  parameter int unsigned FILTER_LEN = 3,
  parameter int unsigned IRQ_REV_A  = 0
) (
  input  logic        m2,
  input  logic        reset,
  input  logic        romsel,
  input  logic        cpu_rw_in,
  input  logic [14:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  input  logic        ppu_a12,
  output logic        irq
);

  localparam int unsigned     LowW   = (FILTER_LEN < 1) ? 1 : $clog2(FILTER_LEN + 1);
  localparam logic [LowW-1:0] LowMax = LowW'(FILTER_LEN);

  localparam logic [2:0] CodeLatch   = 3'b100;
  localparam logic [2:0] CodeReload  = 3'b101;
  localparam logic [2:0] CodeDisable = 3'b110;
  localparam logic [2:0] CodeEnable  = 3'b111;

  // CPU write decode; only A14, A13 and A0 select a register.
  logic       wr_en;
  logic [2:0] wr_code;
  logic       unused_addr_bits;

  assign wr_en            = ~romsel & ~cpu_rw_in;
  assign wr_code          = {cpu_addr_in[14], cpu_addr_in[13], cpu_addr_in[0]};
  assign unused_addr_bits = ^cpu_addr_in[12:1];

  logic            a12_meta_q;
  logic            a12_s_q;
  logic            a12_prev_q;
  logic [LowW-1:0] low_cnt_q, low_cnt_d;
  logic [7:0]      latch_q, latch_d;
  logic [7:0]      counter_q, counter_d;
  logic            reload_q, reload_d;
  logic            enable_q, enable_d;
  logic            pending_q, pending_d;
  logic            clk_event;
  logic            irq_set;

  always_comb begin
    low_cnt_d = low_cnt_q;
    if (a12_s_q) begin
      low_cnt_d = '0;
    end else if (low_cnt_q != LowMax) begin
      low_cnt_d = low_cnt_q + LowW'(1);
    end
  end

  // A rise only counts once A12 has been seen low for the full filter window.
  assign clk_event = a12_s_q & ~a12_prev_q & (low_cnt_q == LowMax);

  always_comb begin
    latch_d   = latch_q;
    counter_d = counter_q;
    reload_d  = reload_q;
    enable_d  = enable_q;
    irq_set   = 1'b0;

    if (clk_event) begin
      if ((counter_q == 8'd0) || reload_q) begin
        counter_d = latch_q;
        reload_d  = 1'b0;
      end else begin
        counter_d = counter_q - 8'd1;
      end
      // Rev A only fires on a transition to zero, not on a zero reload of a zero counter.
      if (IRQ_REV_A != 0) begin
        irq_set = (counter_d == 8'd0) && enable_q && ((counter_q != 8'd0) || reload_q);
      end else begin
        irq_set = (counter_d == 8'd0) && enable_q;
      end
    end

    pending_d = pending_q | irq_set;

    // Register writes are applied last so they override same-edge counter activity.
    if (wr_en) begin
      case (wr_code)
        CodeLatch: latch_d = cpu_data_in;
        CodeReload: begin
          reload_d  = 1'b1;
          counter_d = 8'd0;
        end
        CodeDisable: begin
          enable_d  = 1'b0;
          pending_d = 1'b0;
        end
        CodeEnable: enable_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge m2) begin
    if (reset) begin
      a12_meta_q <= 1'b0;
      a12_s_q    <= 1'b0;
      a12_prev_q <= 1'b0;
      low_cnt_q  <= '0;
      latch_q    <= 8'd0;
      counter_q  <= 8'd0;
      reload_q   <= 1'b0;
      enable_q   <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      a12_meta_q <= ppu_a12;
      a12_s_q    <= a12_meta_q;
      a12_prev_q <= a12_s_q;
      low_cnt_q  <= low_cnt_d;
      latch_q    <= latch_d;
      counter_q  <= counter_d;
      reload_q   <= reload_d;
      enable_q   <= enable_d;
      pending_q  <= pending_d;
    end
  end

  assign irq = ~pending_q;

endmodule
